acs_butterfly: RTL and testbench

Radix-2 add-compare-select butterfly for the 64-state (K=7), rate-1/2 hard-decision Viterbi decoder. It sits directly downstream of the per-state branch metric units: it takes the 2-bit branch metrics for old states 2j and 2j+1, then registers the surviving path metrics for new states j and j+32 together with one decision bit per new state for the traceback memory. Thirty-two instances form the full trellis step; path metrics are routed back to the predecessor inputs externally.

---
 rtl/viterbi_pkg.sv | 26 ++
 rtl/acs_node.sv | 36 +++
 rtl/acs_butterfly.sv | 92 +++++++++
 tb/tb_acs_butterfly.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and the path-metric compare rule for the K=7 rate-1/2 Viterbi ACS array.
// ACS_NORM_EN selects saturating/unsigned metrics instead of modulo metrics.
package viterbi_pkg;

    localparam int K            = 7;
    localparam int NUM_STATES   = 64;
    localparam int BM_W         = 2;
    localparam int PM_W_DEFAULT = 8;
    localparam int INIT_BIG     = 2 ** (PM_W_DEFAULT - 2);

    // Returns 1 when candidate sb must be selected over sa (sb strictly better).
    function automatic logic sb_wins(input logic [31:0] sa, input logic [31:0] sb, input int pm_w);
        logic [31:0] mask;
        logic [31:0] diff;
        mask = 32'((33'd1 << pm_w) - 33'd1);
`ifdef ACS_NORM_EN
        diff = 32'd0;
        return (sb & mask) < (sa & mask);
`else
        // Modulo compare: sa is larger when (sa - sb) is non-zero with a clear MSB.
        diff = (sa - sb) & mask;
        return (diff != 32'd0) && (diff[5'(pm_w - 1)] == 1'b0);
`endif
    endfunction

endpackage

// File: rtl/acs_node.sv
// One add-compare-select: adds branch metrics to two predecessor metrics and keeps the smaller.
// Addition saturates when ACS_NORM_EN is defined, otherwise wraps.
module acs_node
    import viterbi_pkg::*;
#(
    parameter int PM_W = PM_W_DEFAULT
) (
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [BM_W-1:0] bm_a,
    input  logic [BM_W-1:0] bm_b,
    output logic            sel,
    output logic [PM_W-1:0] metric
);

    logic [PM_W-1:0] sa;
    logic [PM_W-1:0] sb;

`ifdef ACS_NORM_EN
    logic [PM_W:0] sum_a_full;
    logic [PM_W:0] sum_b_full;

    assign sum_a_full = {1'b0, pm_a} + (PM_W + 1)'(bm_a);
    assign sum_b_full = {1'b0, pm_b} + (PM_W + 1)'(bm_b);
    assign sa = sum_a_full[PM_W] ? '1 : sum_a_full[PM_W-1:0];
    assign sb = sum_b_full[PM_W] ? '1 : sum_b_full[PM_W-1:0];
`else
    assign sa = pm_a + PM_W'(bm_a);
    assign sb = pm_b + PM_W'(bm_b);
`endif

    // Ties resolve toward the path from old state 2j.
    assign sel    = sb_wins(32'(sa), 32'(sb), PM_W);
    assign metric = sel ? sb : sa;

endmodule

// File: rtl/acs_butterfly.sv
// Radix-2 ACS butterfly: registers survivor metrics and decisions for new states j and j+32.
// Optional normalisation and saturation are enabled by defining ACS_NORM_EN.
module acs_butterfly
    import viterbi_pkg::*;
#(
    parameter int PM_W    = PM_W_DEFAULT,
    parameter int STATE_J = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            frame_start,
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [1:0]      bm_a0,
    input  logic [1:0]      bm_a1,
    input  logic [1:0]      bm_b0,
    input  logic [1:0]      bm_b1,
    input  logic            norm_in,
    output logic [PM_W-1:0] pm_lo,
    output logic [PM_W-1:0] pm_hi,
    output logic            dec_lo,
    output logic            dec_hi,
    output logic            out_valid,
    output logic            norm_req
);

    localparam logic [PM_W-1:0] INIT_BIG_V  = PM_W'(2 ** (PM_W - 2));
    localparam logic [PM_W-1:0] INIT_LO     = (STATE_J == 0) ? '0 : INIT_BIG_V;
    localparam logic [PM_W-1:0] INIT_HI     = INIT_BIG_V;

    logic            sel_lo;
    logic            sel_hi;
    logic [PM_W-1:0] met_lo;
    logic [PM_W-1:0] met_hi;
    logic [PM_W-1:0] next_lo;
    logic [PM_W-1:0] next_hi;
    logic            next_norm_req;

    acs_node #(.PM_W(PM_W)) u_node_lo (
        .pm_a   (pm_a),
        .pm_b   (pm_b),
        .bm_a   (bm_a0),
        .bm_b   (bm_b0),
        .sel    (sel_lo),
        .metric (met_lo)
    );

    acs_node #(.PM_W(PM_W)) u_node_hi (
        .pm_a   (pm_a),
        .pm_b   (pm_b),
        .bm_a   (bm_a1),
        .bm_b   (bm_b1),
        .sel    (sel_hi),
        .metric (met_hi)
    );

`ifdef ACS_NORM_EN
    localparam logic [PM_W-1:0] NORM_OFFSET = PM_W'(2 ** (PM_W - 1));

    // Every butterfly subtracts the same offset, so relative metrics are unchanged.
    assign next_lo       = norm_in ? (met_lo - NORM_OFFSET) : met_lo;
    assign next_hi       = norm_in ? (met_hi - NORM_OFFSET) : met_hi;
    assign next_norm_req = next_lo[PM_W-1] & next_hi[PM_W-1];
`else
    assign next_lo       = met_lo;
    assign next_hi       = met_hi;
    // Modulo metrics never need normalising; norm_in has no effect.
    assign next_norm_req = norm_in & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) begin
            pm_lo     <= INIT_LO;
            pm_hi     <= INIT_HI;
            dec_lo    <= 1'b0;
            dec_hi    <= 1'b0;
            out_valid <= 1'b0;
            norm_req  <= 1'b0;
        end else if (in_valid) begin
            pm_lo     <= next_lo;
            pm_hi     <= next_hi;
            dec_lo    <= sel_lo;
            dec_hi    <= sel_hi;
            out_valid <= 1'b1;
            norm_req  <= next_norm_req;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acs_butterfly.sv
// Self-checking bench for acs_butterfly (PM_W=8) with instances for STATE_J=0 and STATE_J=5.
// Works in both the default build and with ACS_NORM_EN defined.
module tb_acs_butterfly;

    localparam int PM_W = 8;
    localparam int MOD  = 256;
    localparam int HALF = 128;
    localparam int BIG  = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] pm_a = '0;
    logic [7:0] pm_b = '0;
    logic [1:0] bm_a0 = '0;
    logic [1:0] bm_a1 = '0;
    logic [1:0] bm_b0 = '0;
    logic [1:0] bm_b1 = '0;
    logic       norm_in = 1'b0;

    logic [7:0] pm_lo_o [2];
    logic [7:0] pm_hi_o [2];
    logic       dec_lo_o [2];
    logic       dec_hi_o [2];
    logic       out_valid_o [2];
    logic       norm_req_o [2];

    int checks = 0;
    int errors = 0;

    int exp_lo [2];
    int exp_hi [2];
    int exp_dl;
    int exp_dh;
    int exp_ov;
    int exp_nr;
    bit model_ready = 1'b0;

    always #5 clk = ~clk;

    acs_butterfly #(.PM_W(PM_W), .STATE_J(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame_start(frame_start),
        .pm_a(pm_a), .pm_b(pm_b), .bm_a0(bm_a0), .bm_a1(bm_a1), .bm_b0(bm_b0), .bm_b1(bm_b1),
        .norm_in(norm_in), .pm_lo(pm_lo_o[0]), .pm_hi(pm_hi_o[0]), .dec_lo(dec_lo_o[0]),
        .dec_hi(dec_hi_o[0]), .out_valid(out_valid_o[0]), .norm_req(norm_req_o[0])
    );

    acs_butterfly #(.PM_W(PM_W), .STATE_J(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame_start(frame_start),
        .pm_a(pm_a), .pm_b(pm_b), .bm_a0(bm_a0), .bm_a1(bm_a1), .bm_b0(bm_b0), .bm_b1(bm_b1),
        .norm_in(norm_in), .pm_lo(pm_lo_o[1]), .pm_hi(pm_hi_o[1]), .dec_lo(dec_lo_o[1]),
        .dec_hi(dec_hi_o[1]), .out_valid(out_valid_o[1]), .norm_req(norm_req_o[1])
    );

    // Reference ACS straight from the arithmetic rules: smaller survivor wins, ties go to 2j.
    function automatic void acs_ref(input int pa, input int pb, input int ba, input int bb,
                                    output int m, output int d);
        int sa;
        int sb;
        int diff;
        sa = pa + ba;
        sb = pb + bb;
`ifdef ACS_NORM_EN
        if (sa > MOD - 1) sa = MOD - 1;
        if (sb > MOD - 1) sb = MOD - 1;
        d = (sb < sa) ? 1 : 0;
`else
        sa = sa % MOD;
        sb = sb % MOD;
        diff = (sa - sb + MOD) % MOD;
        d = (diff != 0 && diff < HALF) ? 1 : 0;
`endif
        m = (d == 1) ? sb : sa;
    endfunction

    task automatic load_init();
        exp_lo[0] = 0;
        exp_hi[0] = BIG;
        exp_lo[1] = BIG;
        exp_hi[1] = BIG;
        exp_dl = 0;
        exp_dh = 0;
        exp_ov = 0;
        exp_nr = 0;
    endtask

    // Behavioural model, advanced on each rising edge from the inputs held across it.
    always @(posedge clk) begin
        int m_lo;
        int m_hi;
        int d_lo;
        int d_hi;
        if (!rst_n) begin
            load_init();
            model_ready = 1'b1;
        end else if (frame_start) begin
            load_init();
        end else if (in_valid) begin
            acs_ref(int'(pm_a), int'(pm_b), int'(bm_a0), int'(bm_b0), m_lo, d_lo);
            acs_ref(int'(pm_a), int'(pm_b), int'(bm_a1), int'(bm_b1), m_hi, d_hi);
`ifdef ACS_NORM_EN
            if (norm_in) begin
                m_lo = (m_lo - HALF + MOD) % MOD;
                m_hi = (m_hi - HALF + MOD) % MOD;
            end
            exp_nr = (m_lo >= HALF && m_hi >= HALF) ? 1 : 0;
`else
            exp_nr = 0;
`endif
            for (int u = 0; u < 2; u++) begin
                exp_lo[u] = m_lo;
                exp_hi[u] = m_hi;
            end
            exp_dl = d_lo;
            exp_dh = d_hi;
            exp_ov = 1;
        end else begin
            exp_ov = 0;
        end
    end

    task automatic cmp(input string name, input int u, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0d, expected %0d at %0t", name, u, actual, expected, $time);
        end
    endtask

    // Compare process: all outputs of both instances against the model every cycle.
    always @(negedge clk) begin
        if (model_ready) begin
            for (int u = 0; u < 2; u++) begin
                cmp("pm_lo", u, int'(pm_lo_o[u]), exp_lo[u]);
                cmp("pm_hi", u, int'(pm_hi_o[u]), exp_hi[u]);
                cmp("dec_lo", u, int'(dec_lo_o[u]), exp_dl);
                cmp("dec_hi", u, int'(dec_hi_o[u]), exp_dh);
                cmp("out_valid", u, int'(out_valid_o[u]), exp_ov);
                cmp("norm_req", u, int'(norm_req_o[u]), exp_nr);
            end
        end
    end

    task automatic applyStimulus(input bit rn, input bit fs, input bit iv, input int pa, input int pb,
                                 input int ba0, input int bb0, input int ba1, input int bb1,
                                 input bit nin);
        rst_n       = rn;
        frame_start = fs;
        in_valid    = iv;
        pm_a        = 8'(pa);
        pm_b        = 8'(pb);
        bm_a0       = 2'(ba0);
        bm_b0       = 2'(bb0);
        bm_a1       = 2'(ba1);
        bm_b1       = 2'(bb1);
        norm_in     = nin;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectations that pin the model itself.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst j0 pm_lo", int'(pm_lo_o[0]), 0);
        checkOutput("rst j0 pm_hi", int'(pm_hi_o[0]), 64);
        checkOutput("rst j5 pm_lo", int'(pm_lo_o[1]), 64);
        checkOutput("rst j5 pm_hi", int'(pm_hi_o[1]), 64);
        checkOutput("rst out_valid", int'(out_valid_o[0]), 0);
        checkOutput("rst dec", int'(dec_lo_o[0] | dec_hi_o[0]), 0);
        checkOutput("rst norm_req", int'(norm_req_o[0]), 0);

        applyStimulus(1, 0, 1, 10, 7, 2, 1, 0, 2, 0);
        checkOutput("step pm_lo", int'(pm_lo_o[0]), 8);
        checkOutput("step dec_lo", int'(dec_lo_o[0]), 1);
        checkOutput("step pm_hi", int'(pm_hi_o[0]), 9);
        checkOutput("step dec_hi", int'(dec_hi_o[0]), 1);
        checkOutput("step out_valid", int'(out_valid_o[0]), 1);
        checkOutput("step j5 pm_lo", int'(pm_lo_o[1]), 8);
        idle();
        checkOutput("idle out_valid", int'(out_valid_o[0]), 0);
        checkOutput("idle pm_lo held", int'(pm_lo_o[0]), 8);
        checkOutput("idle dec_hi held", int'(dec_hi_o[0]), 1);

        applyStimulus(1, 0, 1, 5, 4, 0, 1, 0, 0, 0);
        checkOutput("tie pm_lo", int'(pm_lo_o[0]), 5);
        checkOutput("tie dec_lo", int'(dec_lo_o[0]), 0);
        checkOutput("tie pm_hi", int'(pm_hi_o[0]), 4);

        applyStimulus(1, 0, 1, 200, 190, 1, 2, 0, 0, 1);
`ifdef ACS_NORM_EN
        checkOutput("norm pm_lo", int'(pm_lo_o[0]), 64);
        checkOutput("norm pm_hi", int'(pm_hi_o[0]), 62);
`else
        checkOutput("norm ignored pm_lo", int'(pm_lo_o[0]), 192);
        checkOutput("norm ignored pm_hi", int'(pm_hi_o[0]), 190);
`endif
        checkOutput("norm dec_lo", int'(dec_lo_o[0]), 1);
        checkOutput("norm dec_hi", int'(dec_hi_o[0]), 1);

        applyStimulus(1, 0, 1, 200, 190, 1, 2, 0, 0, 0);
        checkOutput("big pm_lo", int'(pm_lo_o[0]), 192);
        checkOutput("big pm_hi", int'(pm_hi_o[0]), 190);
`ifdef ACS_NORM_EN
        checkOutput("big norm_req", int'(norm_req_o[0]), 1);
`else
        checkOutput("big norm_req", int'(norm_req_o[0]), 0);
`endif

        applyStimulus(1, 0, 1, 254, 250, 2, 0, 0, 0, 0);
        checkOutput("ovf pm_lo", int'(pm_lo_o[0]), 250);
        checkOutput("ovf dec_lo", int'(dec_lo_o[0]), 1);

        applyStimulus(1, 1, 1, 30, 20, 3, 3, 3, 3, 0);
        checkOutput("fs pm_lo", int'(pm_lo_o[0]), 0);
        checkOutput("fs pm_hi", int'(pm_hi_o[0]), 64);
        checkOutput("fs dec_lo", int'(dec_lo_o[0]), 0);
        checkOutput("fs out_valid", int'(out_valid_o[0]), 0);
        applyStimulus(1, 0, 1, 10, 7, 2, 1, 0, 2, 0);
        checkOutput("after fs pm_lo", int'(pm_lo_o[0]), 8);
        checkOutput("after fs out_valid", int'(out_valid_o[0]), 1);

        applyStimulus(0, 0, 1, 40, 50, 1, 1, 1, 1, 0);
        checkOutput("mid rst j5 pm_lo", int'(pm_lo_o[1]), 64);
        checkOutput("mid rst j0 pm_lo", int'(pm_lo_o[0]), 0);

        // Mixed sequence checked by the model alone.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0));
        end
        idle();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
